// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: opcodes, ALU ops, next-PC
// selects, FSM states and the instruction classes produced by decode.
package multicycle_ctrl_pkg;

    localparam logic [6:0] OPC_R    = 7'h33;
    localparam logic [6:0] OPC_ADDI = 7'h13;
    localparam logic [6:0] OPC_LW   = 7'h03;
    localparam logic [6:0] OPC_SW   = 7'h23;
    localparam logic [6:0] OPC_BEQ  = 7'h63;
    localparam logic [6:0] OPC_JAL  = 7'h6F;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    localparam logic [1:0] PCSEL_PC4 = 2'b00;
    localparam logic [1:0] PCSEL_BR  = 2'b01;
    localparam logic [1:0] PCSEL_JAL = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_e;

    typedef enum logic [2:0] {
        CLS_R, CLS_ADDI, CLS_LW, CLS_SW, CLS_BEQ, CLS_JAL
    } ins_class_e;

    // The state in which an instruction of class c retires (PCwrite, ic++).
    function automatic logic is_final(input state_e s, input ins_class_e c);
        return (s == S_WB) ||
               (s == S_MEM  && c == CLS_SW) ||
               (s == S_EXEC && c == CLS_BEQ);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational instruction decode: opcode/funct fields to class, ALU op,
// operand select, writeback select and legality.
module ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [31:0] ins_i,
    output ins_class_e  cls_o,
    output logic [2:0]  op_o,
    output logic        alusrc_o,
    output logic        mem2reg_o,
    output logic        legal_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       unused_bits;

    assign opcode      = ins_i[6:0];
    assign funct3      = ins_i[14:12];
    assign funct7b5    = ins_i[30];
    assign unused_bits = ^{ins_i[31], ins_i[29:15], ins_i[11:7]};

    always_comb begin
        cls_o     = CLS_R;
        op_o      = ALU_ADD;
        alusrc_o  = 1'b0;
        mem2reg_o = 1'b0;
        legal_o   = 1'b1;
        case (opcode)
            OPC_R: begin
                cls_o = CLS_R;
                case (funct3)
                    3'b000:  op_o = funct7b5 ? ALU_SUB : ALU_ADD;
                    3'b110:  op_o = ALU_OR;
                    3'b111:  op_o = ALU_AND;
                    default: legal_o = 1'b0;
                endcase
            end
            OPC_ADDI: begin
                cls_o    = CLS_ADDI;
                alusrc_o = 1'b1;
            end
            OPC_LW: begin
                cls_o     = CLS_LW;
                alusrc_o  = 1'b1;
                mem2reg_o = 1'b1;
            end
            OPC_SW: begin
                cls_o    = CLS_SW;
                alusrc_o = 1'b1;
            end
            OPC_BEQ: begin
                cls_o = CLS_BEQ;
                op_o  = ALU_SUB;
            end
            OPC_JAL: begin
                cls_o    = CLS_JAL;
                alusrc_o = 1'b1;
            end
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle controller FSM with retired-instruction counter and optional
// instruction budget; all outputs except PCsel come straight from registers.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MAX_INS = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        halt_req,
    input  logic [31:0] ins,
    input  logic        zero,
    output logic        IRwrite,
    output logic        PCwrite,
    output logic [1:0]  PCsel,
    output logic        RegWrite,
    output logic        ALUSrc,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        Mem2Reg,
    output logic [2:0]  op,
    output logic [31:0] ic,
    output logic        busy,
    output logic        done,
    output logic        illegal
);

    localparam logic [31:0] MAX_W = 32'(MAX_INS);

    state_e      state_q;
    ins_class_e  cls_q;
    logic [31:0] ic_q, ic_d;
    logic        IRwrite_q, PCwrite_q, br_q, RegWrite_q, MemRead_q, MemWrite_q;
    logic [1:0]  pcsel_q;
    logic [2:0]  op_q;
    logic        alusrc_q, mem2reg_q, busy_q, done_q, illegal_q;
    logic        final_st, stop_d;

    ins_class_e  dec_cls;
    logic [2:0]  dec_op;
    logic        dec_alusrc, dec_mem2reg, dec_legal;

    ctrl_decode u_decode (
        .ins_i     (ins),
        .cls_o     (dec_cls),
        .op_o      (dec_op),
        .alusrc_o  (dec_alusrc),
        .mem2reg_o (dec_mem2reg),
        .legal_o   (dec_legal)
    );

    assign ic_d     = ic_q + 32'd1;
    assign final_st = is_final(state_q, cls_q);
    assign stop_d   = halt_req || (MAX_INS != 0 && ic_q == MAX_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cls_q      <= CLS_R;
            ic_q       <= '0;
            IRwrite_q  <= 1'b0;
            PCwrite_q  <= 1'b0;
            pcsel_q    <= PCSEL_PC4;
            br_q       <= 1'b0;
            RegWrite_q <= 1'b0;
            MemRead_q  <= 1'b0;
            MemWrite_q <= 1'b0;
            op_q       <= '0;
            alusrc_q   <= 1'b0;
            mem2reg_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            IRwrite_q  <= 1'b0;
            PCwrite_q  <= 1'b0;
            pcsel_q    <= PCSEL_PC4;
            br_q       <= 1'b0;
            RegWrite_q <= 1'b0;
            MemRead_q  <= 1'b0;
            MemWrite_q <= 1'b0;
            if (final_st) begin
                op_q      <= '0;
                alusrc_q  <= 1'b0;
                mem2reg_q <= 1'b0;
                if (stop_d) begin
                    state_q <= S_HALT;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end else begin
                    state_q   <= S_FETCH;
                    IRwrite_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            state_q   <= S_FETCH;
                            IRwrite_q <= 1'b1;
                            busy_q    <= 1'b1;
                        end
                    end
                    S_FETCH: state_q <= S_DECODE;
                    S_DECODE: begin
                        if (!dec_legal) begin
                            state_q   <= S_HALT;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            illegal_q <= 1'b1;
                        end else begin
                            state_q   <= S_EXEC;
                            cls_q     <= dec_cls;
                            op_q      <= dec_op;
                            alusrc_q  <= dec_alusrc;
                            mem2reg_q <= dec_mem2reg;
                            // BEQ retires in EXEC, so its strobe is armed here
                            if (dec_cls == CLS_BEQ) begin
                                PCwrite_q <= 1'b1;
                                br_q      <= 1'b1;
                                ic_q      <= ic_d;
                            end
                        end
                    end
                    S_EXEC: begin
                        case (cls_q)
                            CLS_LW: begin
                                state_q   <= S_MEM;
                                MemRead_q <= 1'b1;
                            end
                            CLS_SW: begin
                                state_q    <= S_MEM;
                                MemWrite_q <= 1'b1;
                                PCwrite_q  <= 1'b1;
                                ic_q       <= ic_d;
                            end
                            default: begin
                                state_q    <= S_WB;
                                RegWrite_q <= 1'b1;
                                PCwrite_q  <= 1'b1;
                                pcsel_q    <= (cls_q == CLS_JAL) ? PCSEL_JAL : PCSEL_PC4;
                                ic_q       <= ic_d;
                            end
                        endcase
                    end
                    S_MEM: begin
                        state_q    <= S_WB;
                        MemRead_q  <= 1'b1;
                        RegWrite_q <= 1'b1;
                        PCwrite_q  <= 1'b1;
                        ic_q       <= ic_d;
                    end
                    default: state_q <= state_q;
                endcase
            end
        end
    end

    // zero is only valid during EXEC, so the branch select is resolved live
    assign PCsel    = (br_q && zero) ? PCSEL_BR : pcsel_q;
    assign IRwrite  = IRwrite_q;
    assign PCwrite  = PCwrite_q;
    assign RegWrite = RegWrite_q;
    assign ALUSrc   = alusrc_q;
    assign MemRead  = MemRead_q;
    assign MemWrite = MemWrite_q;
    assign Mem2Reg  = mem2reg_q;
    assign op       = op_q;
    assign ic       = ic_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: an unlimited-budget instance and a
// MAX_INS=3 instance share stimulus; use3 selects which one is observed.
module tb_multicycle_ctrl;

    typedef enum int {K_R, K_ADDI, K_LW, K_SW, K_BEQ, K_JAL, K_ILL} kind_e;

    typedef struct packed {
        logic [9:0]  ctl;
        logic [4:0]  dec;
        logic        dchk;
        logic [31:0] ic;
        logic [3:0]  cyc;
    } exp_t;

    logic        clk, rst, start, halt_req, zero;
    logic [31:0] ins;

    logic        a_IRwrite, a_PCwrite, a_RegWrite, a_ALUSrc, a_MemRead, a_MemWrite, a_Mem2Reg;
    logic        a_busy, a_done, a_illegal;
    logic [1:0]  a_PCsel;
    logic [2:0]  a_op;
    logic [31:0] a_ic;
    logic        b_IRwrite, b_PCwrite, b_RegWrite, b_ALUSrc, b_MemRead, b_MemWrite, b_Mem2Reg;
    logic        b_busy, b_done, b_illegal;
    logic [1:0]  b_PCsel;
    logic [2:0]  b_op;
    logic [31:0] b_ic;

    logic        use3;
    logic [9:0]  o_ctl;
    logic [4:0]  o_dec;
    logic [31:0] o_ic;

    exp_t        sb[$];
    logic [31:0] m_ic;
    int          budget;
    int          checks, errors;
    string       cur_test;

    multicycle_ctrl #(.MAX_INS(0)) dut (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .ins(ins), .zero(zero),
        .IRwrite(a_IRwrite), .PCwrite(a_PCwrite), .PCsel(a_PCsel), .RegWrite(a_RegWrite),
        .ALUSrc(a_ALUSrc), .MemRead(a_MemRead), .MemWrite(a_MemWrite), .Mem2Reg(a_Mem2Reg),
        .op(a_op), .ic(a_ic), .busy(a_busy), .done(a_done), .illegal(a_illegal)
    );

    multicycle_ctrl #(.MAX_INS(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .ins(ins), .zero(zero),
        .IRwrite(b_IRwrite), .PCwrite(b_PCwrite), .PCsel(b_PCsel), .RegWrite(b_RegWrite),
        .ALUSrc(b_ALUSrc), .MemRead(b_MemRead), .MemWrite(b_MemWrite), .Mem2Reg(b_Mem2Reg),
        .op(b_op), .ic(b_ic), .busy(b_busy), .done(b_done), .illegal(b_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        if (use3) begin
            o_ctl = {b_IRwrite, b_PCwrite, b_PCsel, b_RegWrite, b_MemRead, b_MemWrite,
                     b_busy, b_done, b_illegal};
            o_dec = {b_op, b_ALUSrc, b_Mem2Reg};
            o_ic  = b_ic;
        end else begin
            o_ctl = {a_IRwrite, a_PCwrite, a_PCsel, a_RegWrite, a_MemRead, a_MemWrite,
                     a_busy, a_done, a_illegal};
            o_dec = {a_op, a_ALUSrc, a_Mem2Reg};
            o_ic  = a_ic;
        end
    end

    function automatic logic [9:0] ctlv(input logic irw, input logic pcw, input logic [1:0] pcs,
                                        input logic rw, input logic mr, input logic mw,
                                        input logic bsy, input logic dn, input logic ill);
        return {irw, pcw, pcs, rw, mr, mw, bsy, dn, ill};
    endfunction

    // Scoreboard monitor: one expected entry per clock while instructions are in flight.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (o_ctl !== e.ctl) begin
                errors++;
                $display("FAIL %s cyc%0d ctl: got %b expected %b", cur_test, e.cyc, o_ctl, e.ctl);
            end
            checks++;
            if (o_ic !== e.ic) begin
                errors++;
                $display("FAIL %s cyc%0d ic: got %0d expected %0d", cur_test, e.cyc, o_ic, e.ic);
            end
            if (e.dchk) begin
                checks++;
                if (o_dec !== e.dec) begin
                    errors++;
                    $display("FAIL %s cyc%0d op/ALUSrc/Mem2Reg: got %b expected %b",
                             cur_test, e.cyc, o_dec, e.dec);
                end
            end
        end
    end

    // Call before the edge that enters FETCH; returns just after the edge entering
    // the instruction's last cycle (DECODE for an illegal word).
    task automatic issue(input logic [31:0] w, input logic z, input logic hreq,
                         input kind_e k, input logic [2:0] eop);
        int   n;
        logic asrc, m2r, halting, fin;
        logic [1:0] pcs;
        exp_t e;
        n    = (k == K_BEQ) ? 3 : (k == K_LW) ? 5 : (k == K_ILL) ? 2 : 4;
        asrc = (k == K_ADDI) || (k == K_LW) || (k == K_SW) || (k == K_JAL);
        m2r  = (k == K_LW);
        @(posedge clk); #2;
        start = 1'b0; ins = w; zero = z; halt_req = hreq;
        for (int c = 1; c <= n; c++) begin
            fin = (k != K_ILL) && (c == n);
            pcs = !fin ? 2'b00 : (k == K_JAL) ? 2'b10 : (k == K_BEQ && z) ? 2'b01 : 2'b00;
            e.ctl  = ctlv(c == 1, fin, pcs, fin && k != K_SW && k != K_BEQ,
                          k == K_LW && c >= 4, k == K_SW && c == 4, 1'b1, 1'b0, 1'b0);
            e.dchk = (k != K_ILL) && (c >= 3);
            e.dec  = {eop, asrc, m2r};
            e.ic   = fin ? m_ic + 32'd1 : m_ic;
            e.cyc  = 4'(c);
            sb.push_back(e);
        end
        if (k != K_ILL) m_ic = m_ic + 32'd1;
        halting = (k == K_ILL) || hreq || (budget != 0 && m_ic == 32'(budget));
        if (halting) begin
            e.ctl  = ctlv(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, k == K_ILL);
            e.dchk = 1'b0;
            e.dec  = '0;
            e.ic   = m_ic;
            e.cyc  = 4'(n + 1);
            sb.push_back(e);
        end
        repeat (n - 1) begin @(posedge clk); #2; end
    endtask

    task automatic do_reset();
        for (int i = 0; i < 8 && sb.size() != 0; i++) @(negedge clk);
        #1;
        rst = 1'b1; start = 1'b0; halt_req = 1'b0; zero = 1'b0;
        @(posedge clk); #2;
        rst = 1'b0;
        m_ic = '0;
    endtask

    task automatic test_reset();
        cur_test = "reset";
        rst = 1'b1; start = 1'b1; halt_req = 1'b1; zero = 1'b1; ins = 32'h0020_81B3;
        repeat (3) @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            @(negedge clk);
            use3 = (d == 1); #1;
            checks++;
            if (o_ctl !== 10'd0) begin errors++; $display("FAIL reset ctl dut%0d: got %b expected 0", d, o_ctl); end
            checks++;
            if (o_dec !== 5'd0) begin errors++; $display("FAIL reset op dut%0d: got %b expected 0", d, o_dec); end
            checks++;
            if (o_ic !== 32'd0) begin errors++; $display("FAIL reset ic dut%0d: got %0d expected 0", d, o_ic); end
        end
        use3 = 1'b0;
        start = 1'b0; halt_req = 1'b0; zero = 1'b0;
        @(posedge clk); #2; rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (o_ctl !== 10'd0) begin errors++; $display("FAIL idle_no_start ctl: got %b expected 0", o_ctl); end
        end
        m_ic = '0;
    endtask

    task automatic test_alu_r();
        cur_test = "alu_r";
        do_reset();
        start = 1'b1;
        issue(32'h0020_81B3, 1'b0, 1'b0, K_R, 3'b010);
        issue(32'h0020_E233, 1'b0, 1'b0, K_R, 3'b001);
        @(negedge clk);
        checks++;
        if (o_ic !== 32'd2) begin errors++; $display("FAIL add_or ic: got %0d expected 2", o_ic); end
        issue(32'h4020_81B3, 1'b0, 1'b0, K_R, 3'b110);
        issue(32'h0020_F1B3, 1'b0, 1'b0, K_R, 3'b000);
    endtask

    task automatic test_back_to_back_mem();
        cur_test = "lw_sw";
        do_reset();
        start = 1'b1;
        issue(32'h0000_2183, 1'b0, 1'b0, K_LW, 3'b010);
        issue(32'h0030_2023, 1'b0, 1'b0, K_SW, 3'b010);
        issue(32'h0010_0093, 1'b0, 1'b0, K_ADDI, 3'b010);
    endtask

    task automatic test_beq();
        cur_test = "beq";
        do_reset();
        start = 1'b1;
        issue(32'h0020_8463, 1'b1, 1'b0, K_BEQ, 3'b110);
        issue(32'h0020_8463, 1'b0, 1'b0, K_BEQ, 3'b110);
        issue(32'h0020_8463, 1'b1, 1'b0, K_BEQ, 3'b110);
    endtask

    task automatic test_jal_halt();
        cur_test = "jal_halt";
        do_reset();
        start = 1'b1;
        issue(32'h0080_00EF, 1'b0, 1'b1, K_JAL, 3'b010);
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (o_ctl !== ctlv(0, 0, 2'b00, 0, 0, 0, 0, 1, 0)) begin
                errors++; $display("FAIL jal_halt quiet ctl: got %b expected 0000000010", o_ctl);
            end
        end
    endtask

    task automatic test_illegal();
        cur_test = "illegal";
        do_reset();
        start = 1'b1;
        issue(32'h0020_81B3, 1'b0, 1'b0, K_R, 3'b010);
        issue(32'hFFFF_FFFF, 1'b0, 1'b0, K_ILL, 3'b000);
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (o_ctl !== ctlv(0, 0, 2'b00, 0, 0, 0, 0, 1, 1) || o_ic !== 32'd1) begin
                errors++; $display("FAIL illegal quiet: ctl %b ic %0d expected ctl 0000000011 ic 1", o_ctl, o_ic);
            end
        end
        cur_test = "illegal_funct3";
        do_reset();
        start = 1'b1;
        issue(32'h0020_91B3, 1'b0, 1'b0, K_ILL, 3'b000);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (o_ic !== 32'd0) begin errors++; $display("FAIL illegal_funct3 ic: got %0d expected 0", o_ic); end
    endtask

    task automatic test_rst_mid_exec();
        cur_test = "rst_mid_exec";
        do_reset();
        start = 1'b1;
        issue(32'h0020_81B3, 1'b0, 1'b0, K_R, 3'b010);
        @(posedge clk); #2;
        ins = 32'h0020_81B3; zero = 1'b1;
        repeat (2) begin @(posedge clk); #2; end
        checks++;
        if (o_ctl !== ctlv(0, 0, 2'b00, 0, 0, 0, 1, 0, 0) || o_dec !== 5'b01000) begin
            errors++; $display("FAIL rst_mid_exec pre: ctl %b dec %b expected 0000000100 01000", o_ctl, o_dec);
        end
        rst = 1'b1; #1;
        checks++;
        if (o_ctl !== 10'd0 || o_dec !== 5'd0) begin
            errors++; $display("FAIL rst_mid_exec outputs: ctl %b dec %b expected 0", o_ctl, o_dec);
        end
        checks++;
        if (o_ic !== 32'd0) begin errors++; $display("FAIL rst_mid_exec ic: got %0d expected 0", o_ic); end
        #4; rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (o_ctl !== 10'd0) begin errors++; $display("FAIL rst_mid_exec idle: got %b expected 0", o_ctl); end
        end
        @(posedge clk); #2; start = 1'b1;
        @(posedge clk); #2; start = 1'b0;
        @(negedge clk);
        checks++;
        if (o_ctl !== ctlv(1, 0, 2'b00, 0, 0, 0, 1, 0, 0)) begin
            errors++; $display("FAIL rst_mid_exec restart: got %b expected 1000000100", o_ctl);
        end
    endtask

    task automatic test_budget();
        use3 = 1'b1; budget = 3;
        for (int run = 0; run < 2; run++) begin
            cur_test = (run == 0) ? "budget" : "budget_and_halt_req";
            do_reset();
            start = 1'b1;
            issue(32'h0010_0093, 1'b0, 1'b0, K_ADDI, 3'b010);
            issue(32'h0010_0093, 1'b0, 1'b0, K_ADDI, 3'b010);
            issue(32'h0010_0093, 1'b0, run == 1, K_ADDI, 3'b010);
            @(posedge clk);
            repeat (4) begin
                @(negedge clk);
                checks++;
                if (o_ctl !== ctlv(0, 0, 2'b00, 0, 0, 0, 0, 1, 0) || o_ic !== 32'd3) begin
                    errors++;
                    $display("FAIL %s quiet: ctl %b ic %0d expected ctl 0000000010 ic 3", cur_test, o_ctl, o_ic);
                end
            end
        end
        do_reset();
        use3 = 1'b0; budget = 0;
    endtask

    initial begin
        checks = 0; errors = 0; use3 = 1'b0; budget = 0; m_ic = '0;
        rst = 1'b1; start = 1'b0; halt_req = 1'b0; zero = 1'b0; ins = '0;
        test_reset();
        test_alu_r();
        test_back_to_back_mem();
        test_beq();
        test_jal_halt();
        test_illegal();
        test_rst_mid_exec();
        test_budget();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: MAX_INS, default 0, instruction budget; 0 = unlimited.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  level; leaves IDLE when sampled high.
REQ-005 halt_req  input  1  level; requests a stop at the next instruction boundary.
REQ-006 ins  input  32  instruction word from the fetch stage; valid from DECODE onward.
REQ-007 zero  input  1  ALU zero flag; valid in EXEC.
REQ-008 IRwrite  output  1  latches the instruction register.
REQ-009 PCwrite  output  1  one-cycle PC update strobe.
REQ-010 PCsel  output  2  next-PC source: 00 = PC+4, 01 = branch target, 10 = JAL target.
REQ-011 RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg  output  1 each  datapath controls.
REQ-012 op  output  3  ALU operation: 000 AND, 001 OR, 010 ADD, 110 SUB.
REQ-013 ic  output  32  retired-instruction count.
REQ-014 busy  output  1; done  output  1; illegal  output  1.

Function
REQ-015 States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-016 IDLE goes to FETCH when start=1; otherwise it stays in IDLE.
REQ-017 FETCH goes to DECODE and asserts IRwrite for exactly that cycle.
REQ-018 DECODE classifies ins[6:0]:
  - 0x33 R, 0x13 ADDI, 0x03 LW, 0x23 SW, 0x63 BEQ, 0x6F JAL.
  - Any other opcode goes to HALT with illegal=1.
REQ-019 Sequence per class:
  - R / ADDI / JAL: FETCH, DECODE, EXEC, WB (4 cycles).
  - LW: FETCH, DECODE, EXEC, MEM, WB (5 cycles).
  - SW: FETCH, DECODE, EXEC, MEM (4 cycles).
  - BEQ: FETCH, DECODE, EXEC (3 cycles).
REQ-020 op, ALUSrc and Mem2Reg are set in DECODE and held stable until the instruction's final state ends.
REQ-021 op mapping:
  - R funct3=000 with funct7[5]=0 gives ADD; with funct7[5]=1 gives SUB.
  - R funct3=110 gives OR; R funct3=111 gives AND.
  - ADDI, LW, SW and JAL give ADD; BEQ gives SUB.
  - Any other R funct3 is illegal.
REQ-022 ALUSrc=1 for ADDI, LW, SW and JAL; ALUSrc=0 for R and BEQ.
REQ-023 Mem2Reg=1 only for LW.
REQ-024 RegWrite is asserted only in WB.
REQ-025 MemWrite is asserted only in MEM for SW.
REQ-026 MemRead is asserted in MEM and WB for LW only.
REQ-027 PCwrite is asserted exactly once per instruction, in its final state, with:
  - PCsel=01 for BEQ when zero=1;
  - PCsel=10 for JAL;
  - PCsel=00 otherwise.
REQ-028 ic increments by 1 (wrapping at 2^32) in the same cycle as PCwrite.
REQ-029 After the final state, the FSM goes to HALT if either condition holds; otherwise it goes to FETCH:
  - halt_req=1;
  - MAX_INS!=0 and the incremented ic equals MAX_INS.
REQ-030 HALT is terminal until reset:
  - done=1, busy=0;
  - all strobes are 0.
REQ-031 busy=1 in every state except IDLE and HALT.
REQ-032 An illegal instruction does not increment ic and asserts no PCwrite.
REQ-033 If halt_req and the budget are met in the same cycle, the single HALT entry occurs with illegal=0.

Reset
REQ-034 While rst=1:
  - state is IDLE;
  - ic is 0;
  - every output is 0.
REQ-035 rst asserted mid-instruction aborts the instruction:
  - no partial PCwrite, RegWrite or MemWrite after the rst edge;
  - after rst deasserts, the FSM restarts only via start.

Structure
REQ-036 A shared package holds:
  - the opcode constants;
  - the ALU op encodings (000/001/010/110);
  - the PCsel encodings;
  - the state enumeration.
REQ-037 Combinational decode (opcode/funct to class, op, ALUSrc, Mem2Reg, legal) is a single sub-module, ctrl_decode; the FSM and counter stay in multicycle_ctrl.

Verification
REQ-038 rst pulse mid-EXEC of an ADD:
  - required: all outputs 0 and ic=0 at once;
  - then start=1 gives IRwrite on the next clk.
REQ-039 ins=0x002081B3 (add x3,x1,x2), then ins=0x0020E233 (or):
  - add: RegWrite only in cycle 4 with op=010, PCsel=00;
  - or: op=001;
  - required: ic=2.
REQ-040 LW 0x00002183 then SW 0x00302023:
  - LW: MemRead in cycles 4-5, Mem2Reg=1, RegWrite in cycle 5;
  - SW: MemWrite in cycle 4 only, RegWrite never asserted.
REQ-041 BEQ 0x00208463:
  - with zero=1: PCwrite in cycle 3 with PCsel=01;
  - with zero=0: PCsel=00;
  - required: 3 cycles in both cases.
REQ-042 MAX_INS=3 running ADDI 0x00100093 repeatedly:
  - required: HALT after the 3rd PCwrite, done=1, ic=3, and no further strobes.
REQ-043 ins=0xFFFFFFFF:
  - required: HALT with illegal=1, ic unchanged, PCwrite never asserted.
